// File: rtl/snake_head_ctrl.sv
// Snake head controller: turns held arrow-key directions into timed head moves
// on a bounded grid, with the no-reversal rule and wall-collision detection.
module snake_head_ctrl #(
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned X_W      = 5,
    parameter int unsigned Y_W      = 5,
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned START_X  = 16,
    parameter int unsigned START_Y  = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           dir_valid,
    input  logic [1:0]     dir,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [1:0]     cur_dir,
    output logic           move_pulse,
    output logic           running,
    output logic           game_over
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [X_W-1:0]   X_START   = X_W'(START_X);
    localparam logic [Y_W-1:0]   Y_START   = Y_W'(START_Y);
    localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_L = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        OVER = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [1:0]       cur_dir_q, cur_dir_d;
    logic [1:0]       next_dir_q, next_dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    logic             tick;
    logic             reversal;
    logic             hit;
    logic [X_W-1:0]   cand_x;
    logic [Y_W-1:0]   cand_y;

    assign tick     = (cnt_q == TICK_LAST);
    // Checked against the committed direction so two quick turns cannot reverse.
    assign reversal = (dir[1] == cur_dir_q[1]) && (dir[0] != cur_dir_q[0]);

    // Candidate head for the pending direction; a wall hit leaves it unchanged.
    always_comb begin
        cand_x = x_q;
        cand_y = y_q;
        hit    = 1'b0;
        case (next_dir_q)
            DIR_R: if (x_q == X_MAX) hit = 1'b1; else cand_x = x_q + X_W'(1);
            DIR_L: if (x_q == '0)    hit = 1'b1; else cand_x = x_q - X_W'(1);
            DIR_U: if (y_q == '0)    hit = 1'b1; else cand_y = y_q - Y_W'(1);
            DIR_D: if (y_q == Y_MAX) hit = 1'b1; else cand_y = y_q + Y_W'(1);
            default: hit = 1'b0;
        endcase
    end

    // Next-state and datapath updates; start always takes priority over a tick.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cur_dir_d  = cur_dir_q;
        next_dir_d = next_dir_q;
        cnt_d      = cnt_q;
        pulse_d    = 1'b0;

        if (start) begin
            state_d    = RUN;
            x_d        = X_START;
            y_d        = Y_START;
            cur_dir_d  = DIR_R;
            next_dir_d = DIR_R;
            cnt_d      = '0;
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                RUN: begin
                    if (tick) begin
                        cnt_d = '0;
                        if (hit) begin
                            state_d = OVER;
                        end else begin
                            x_d       = cand_x;
                            y_d       = cand_y;
                            cur_dir_d = next_dir_q;
                            pulse_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (dir_valid && !reversal) begin
                            next_dir_d = dir;
                        end
                    end
                end
                OVER: cnt_d = '0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= X_START;
            y_q        <= Y_START;
            cur_dir_q  <= DIR_R;
            next_dir_q <= DIR_R;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cur_dir_q  <= cur_dir_d;
            next_dir_q <= next_dir_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    assign head_x     = x_q;
    assign head_y     = y_q;
    assign cur_dir    = cur_dir_q;
    assign move_pulse = pulse_q;
    assign running    = (state_q == RUN);
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl on an 8x8 grid with a 4-cycle move period; directed
// scenarios followed by random key traffic, all checked against a move-level model.
module tb_snake_head_ctrl;

    localparam int GW = 8;
    localparam int GH = 8;
    localparam int TD = 4;
    localparam int SX = 4;
    localparam int SY = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir_valid;
    logic [1:0] dir;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic [1:0] cur_dir;
    logic       move_pulse;
    logic       running;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    snake_head_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .X_W(3), .Y_W(3),
        .TICK_DIV(TD), .START_X(SX), .START_Y(SY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dir_valid(dir_valid), .dir(dir),
        .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir),
        .move_pulse(move_pulse), .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Game model: 0 idle, 1 playing, 2 lost; direction 0..3 = right,left,up,down
    int m_game, m_x, m_y, m_cur, m_next, m_since, m_pulse;
    int dx_of[4]   = '{1, -1, 0, 0};
    int dy_of[4]   = '{0, 0, -1, 1};
    int opposite[4] = '{1, 0, 3, 2};

    task automatic model_reset();
        m_game = 0; m_x = SX; m_y = SY; m_cur = 0; m_next = 0; m_since = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit s, input bit dv, input int d);
        int nx, ny;
        m_pulse = 0;
        if (s) begin
            m_game = 1; m_x = SX; m_y = SY; m_cur = 0; m_next = 0; m_since = 0;
        end else if (m_game == 1) begin
            if (m_since == TD - 1) begin
                m_since = 0;
                nx = m_x + dx_of[m_next];
                ny = m_y + dy_of[m_next];
                if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                    m_game = 2;
                end else begin
                    m_x = nx; m_y = ny; m_cur = m_next; m_pulse = 1;
                end
            end else begin
                m_since++;
                if (dv && d != opposite[m_cur]) m_next = d;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("head_x",     32'(head_x),     32'(m_x));
        check("head_y",     32'(head_y),     32'(m_y));
        check("cur_dir",    32'(cur_dir),    32'(m_cur));
        check("move_pulse", 32'(move_pulse), 32'(m_pulse));
        check("running",    32'(running),    32'(m_game == 1));
        check("game_over",  32'(game_over),  32'(m_game == 2));
    endtask

    task automatic cyc(input bit s, input bit dv, input logic [1:0] d);
        @(negedge clk);
        start = s; dir_valid = dv; dir = d;
        @(posedge clk);
        model_step(s, dv, int'(d));
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir_valid = 1'b0; dir = 2'b00;
        model_reset();
        #12;
        compare_all();
        check("rst_head_x", 32'(head_x), 32'(SX));
        @(negedge clk) rst = 1'b0;

        // Straight run to the right wall from reset
        idle(3);
        cyc(1'b1, 1'b0, 2'b00);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b0, 2'b00);
            if (i == 4) begin
                check("t1_first_pulse", 32'(move_pulse), 32'd1);
                check("t1_first_x", 32'(head_x), 32'd5);
                check("t1_cur_dir", 32'(cur_dir), 32'd0);
            end
            if (i == 12) check("t1_third_x", 32'(head_x), 32'd7);
            if (i == 16) begin
                check("t1_over", 32'(game_over), 32'd1);
                check("t1_frozen_x", 32'(head_x), 32'd7);
            end
        end

        // Restart from OVER
        cyc(1'b1, 1'b0, 2'b00);
        check("t6_restart_x", 32'(head_x), 32'd4);
        check("t6_running", 32'(running), 32'd1);
        check("t6_not_over", 32'(game_over), 32'd0);
        idle(3);
        cyc(1'b0, 1'b0, 2'b00);
        check("t6_first_pulse", 32'(move_pulse), 32'd1);

        // Held reversal is discarded
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 2'b01);
        check("t2_x", 32'(head_x), 32'd7);
        check("t2_dir", 32'(cur_dir), 32'd0);

        // Up then left before the tick: left is judged against cur_dir
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 2'b10);
        cyc(1'b0, 1'b1, 2'b01);
        idle(2);
        check("t3_y", 32'(head_y), 32'd3);
        check("t3_x", 32'(head_x), 32'd4);
        check("t3_dir", 32'(cur_dir), 32'd2);

        // Request only in the tick cycle is ignored
        cyc(1'b1, 1'b0, 2'b00);
        idle(3);
        cyc(1'b0, 1'b1, 2'b11);
        check("t4_x", 32'(head_x), 32'd5);
        check("t4_dir", 32'(cur_dir), 32'd0);
        idle(4);
        check("t4_next_x", 32'(head_x), 32'd6);

        // Asynchronous reset between ticks
        cyc(1'b1, 1'b0, 2'b00);
        idle(2);
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all();
        check("t5_rst_x", 32'(head_x), 32'd4);
        check("t5_rst_run", 32'(running), 32'd0);
        @(negedge clk) rst = 1'b0;
        cyc(1'b1, 1'b0, 2'b00);
        idle(3);
        cyc(1'b0, 1'b0, 2'b00);
        check("t5_pulse", 32'(move_pulse), 32'd1);
        check("t5_x", 32'(head_x), 32'd5);

        // Start landing on a tick cycle wins over the move
        idle(3);
        cyc(1'b1, 1'b0, 2'b00);
        check("t6b_x", 32'(head_x), 32'd4);
        check("t6b_no_pulse", 32'(move_pulse), 32'd0);

        // Random key traffic with occasional restarts
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
